// File: rtl/instr_pack_pkg.sv
// Shared formats, opcode constants, state encoding and packing helpers for instr_packer.
package instr_pack_pkg;

  typedef enum logic [1:0] {
    FMT_R    = 2'b00,
    FMT_I    = 2'b01,
    FMT_J    = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

  localparam logic [5:0]  OP_SPECIAL        = 6'b000000;
  localparam logic [5:0]  OP_J              = 6'b000010;
  localparam logic [5:0]  OP_JAL            = 6'b000011;
  localparam logic [5:0]  OP_BEQ            = 6'b000100;
  localparam logic [5:0]  OP_BNE            = 6'b000101;
  localparam logic [5:0]  FUNCT_JR          = 6'b001000;
  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic logic [31:0] pack_word(
    input fmt_e        f,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] index
  );
    case (f)
      FMT_R:   return {op, rs, rt, rd, shamt, funct};
      FMT_I:   return {op, rs, rt, imm};
      FMT_J:   return {op, index};
      default: return NOP_WORD;
    endcase
  endfunction

  // Words that are followed by a branch delay slot.
  function automatic logic is_ctrl_xfer(
    input fmt_e       f,
    input logic [5:0] op,
    input logic [5:0] funct
  );
    return (f == FMT_J) ||
           (f == FMT_I && (op == OP_BEQ || op == OP_BNE)) ||
           (f == FMT_R && op == OP_SPECIAL && funct == FUNCT_JR);
  endfunction

endpackage

// File: rtl/instr_pack_fifo.sv
// Synchronous DEPTH-entry FIFO of {addr, instr} with flush; head reads as zero while empty.
module instr_pack_fifo
  import instr_pack_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  fifo_entry_t i_data,
  input  logic        i_pop,
  output fifo_entry_t o_data,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the head is masked to zero while empty so outputs are defined.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_packer.sv
// Packs decoded MIPS fields into addressed 32-bit words and queues them in a small FIFO.
// Optional branch delay-slot nop insertion is enabled by defining INSTR_PACK_DELAY_SLOT_EN.
module instr_packer
  import instr_pack_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] instr_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);

  fmt_e        w_fmt;
  state_e      w_state;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_beat_push;
  logic        w_slot_push;
  logic        w_push;
  logic        w_pop;
  fifo_entry_t w_push_data;
  fifo_entry_t w_head;
  logic [31:0] r_addr;
  logic        r_err;

  assign w_fmt = fmt_e'(fmt);

  // in_ready depends only on registered state and restart, never on out_ready.
  assign in_ready    = !w_full && (w_state == ST_IDLE) && !restart;
  assign w_accept    = in_valid && in_ready;
  assign w_beat_push = w_accept && (w_fmt != FMT_RSVD);
  assign w_slot_push = (w_state == ST_SLOT) && !w_full && !restart;
  assign w_push      = w_beat_push || w_slot_push;
  assign w_pop       = out_valid && out_ready && !restart;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_push_data.addr  = r_addr;
    w_push_data.instr = NOP_WORD;
    if (!w_slot_push) begin
      w_push_data.instr = pack_word(w_fmt, opcode, rs, rt, rd, shamt, funct,
                                    immediate, instr_index);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else if (restart) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_addr <= r_addr + 32'd4;
      if (w_accept && w_fmt == FMT_RSVD) r_err <= 1'b1;
    end
  end

`ifdef INSTR_PACK_DELAY_SLOT_EN
  state_e r_state;
  state_e w_state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_beat_push && is_ctrl_xfer(w_fmt, opcode, funct)) w_state_nxt = ST_SLOT;
        ST_SLOT: if (!w_full) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_state = r_state;
`else
  assign w_state = ST_IDLE;
`endif

  instr_pack_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (restart),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_instr = w_head.instr;
  assign out_addr  = w_head.addr;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: queue-based reference model plus directed literal checks.
module tb_instr_packer;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 2;
`ifdef INSTR_PACK_DELAY_SLOT_EN
  localparam bit SLOT_EN = 1'b1;
`else
  localparam bit SLOT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = 2'b00;
  logic [5:0]  opcode = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] immediate = '0;
  logic [25:0] instr_index = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_packer #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fmt         (fmt),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .immediate   (immediate),
    .instr_index (instr_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .err         (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Field placement by weights rather than concatenation.
  function automatic logic [31:0] model_word(
    input logic [1:0] f, input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
    input logic [4:0] c, input logic [4:0] s, input logic [5:0] fn, input logic [15:0] im,
    input logic [25:0] ix);
    logic [31:0] w;
    w = 32'(op) * 32'h0400_0000;
    if (f == 2'd0)
      w = w + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(c) * 32'h0000_0800
            + 32'(s) * 32'h0000_0040 + 32'(fn);
    else if (f == 2'd1)
      w = w + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(im);
    else
      w = w + 32'(ix);
    return w;
  endfunction

  function automatic bit model_ctrl(input logic [1:0] f, input logic [5:0] op, input logic [5:0] fn);
    if (f == 2'd2) return 1'b1;
    if (f == 2'd1) return (op == 6'd4) || (op == 6'd5);
    if (f == 2'd0) return (op == 6'd0) && (fn == 6'd8);
    return 1'b0;
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } ent_t;

  // Reference model: queue of words the consumer must see, in order. A delay-slot nop is
  // queued at accept time but is only in the DUT FIFO once m_pend clears.
  ent_t        exp_q[$];
  ent_t        m_ent;
  logic [31:0] m_addr = BASE;
  bit          m_err = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cnt;
  bit          m_rdy;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      m_pend = 1'b0;
    end else begin
      m_cnt = exp_q.size() - (m_pend ? 1 : 0);
      m_rdy = !restart && (m_cnt < DEPTH) && !m_pend;
      check("mon_in_ready", 32'(in_ready), 32'(m_rdy));
      check("mon_out_valid", 32'(out_valid), 32'(m_cnt != 0));
      check("mon_err", 32'(err), 32'(m_err));
      if (m_cnt != 0) begin
        check("mon_out_instr", out_instr, exp_q[0].instr);
        check("mon_out_addr", out_addr, exp_q[0].addr);
      end
      if (restart) begin
        exp_q.delete();
        m_addr = BASE;
        m_err  = 1'b0;
        m_pend = 1'b0;
      end else begin
        if (m_pend && m_cnt < DEPTH) m_pend = 1'b0;
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && m_rdy) begin
          if (fmt == 2'b11) begin
            m_err = 1'b1;
          end else begin
            m_ent.addr  = m_addr;
            m_ent.instr = model_word(fmt, opcode, rs, rt, rd, shamt, funct, immediate, instr_index);
            exp_q.push_back(m_ent);
            m_addr = m_addr + 32'd4;
            if (SLOT_EN && model_ctrl(fmt, opcode, funct)) begin
              m_ent.addr  = m_addr;
              m_ent.instr = 32'h0;
              exp_q.push_back(m_ent);
              m_addr = m_addr + 32'd4;
              m_pend = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
                          input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ix);
    fmt = f; opcode = op; rs = a; rt = b; rd = c; shamt = s;
    funct = fn; immediate = im; instr_index = ix;
  endtask

  // Offers one beat until accepted (bounded), returning #1 after the accepting edge.
  task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] c, input logic [4:0] s,
                      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ix);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    set_beat(f, op, a, b, c, s, fn, im, ix);
    in_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    check("restart_in_ready", 32'(in_ready), 32'd0);
    tick();
    restart = 1'b0;
  endtask

  logic [31:0] split_w;

  initial begin
    // Pin the model against hand-computed words.
    check("model_j",   model_word(2'd2, 6'd3, 0, 0, 0, 0, 0, 16'h0, 26'h0000c01), 32'h0c000c01);
    check("model_r",   model_word(2'd0, 6'd0, 1, 2, 3, 0, 6'h21, 16'h0, 26'h0), 32'h00221821);
    check("model_i",   model_word(2'd1, 6'h0d, 0, 1, 0, 0, 0, 16'h1234, 26'h0), 32'h34011234);
    check("model_beq", model_word(2'd1, 6'd4, 1, 2, 0, 0, 0, 16'hffff, 26'h0), 32'h1022ffff);

    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_out_addr",  out_addr,       32'd0);
    check("rst_err",       32'(err),       32'd0);
    reset = 1'b1;
    tick();

    // J beat visible one cycle after accept.
    send(2'd2, 6'd3, 0, 0, 0, 0, 0, 16'h0, 26'h0000c01);
    check("j_valid", 32'(out_valid), 32'd1);
    check("j_instr", out_instr, 32'h0c000c01);
    check("j_addr",  out_addr,  32'h0000_3000);
`ifdef INSTR_PACK_DELAY_SLOT_EN
    check("j_slot_ready", 32'(in_ready), 32'd0);
`else
    check("j_ready", 32'(in_ready), 32'd1);
`endif
    drain();

    // R beat and round trip through the field splitter.
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
    check("r_instr", out_instr, 32'h00221821);
`ifdef INSTR_PACK_DELAY_SLOT_EN
    check("r_addr", out_addr, 32'h0000_3008);
`else
    check("r_addr", out_addr, 32'h0000_3004);
`endif
    split_w = out_instr;
    check("split_rs", 32'(split_w[25:21]), 32'd1);
    check("split_rt", 32'(split_w[20:16]), 32'd2);
    check("split_rd", 32'(split_w[15:11]), 32'd3);
    drain();

    // Backpressure: two I beats fill the FIFO; full-with-pop still refuses.
    pulse_restart();
    send(2'd1, 6'h0d, 5'd0, 5'd1, 0, 0, 0, 16'h1234, 26'h0);
    send(2'd1, 6'h0d, 5'd0, 5'd1, 0, 0, 0, 16'h1234, 26'h0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_head_instr", out_instr, 32'h34011234);
    check("bp_head_addr",  out_addr,  32'h0000_3000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_pop_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_addr_2", out_addr, 32'h0000_3004);
    check("bp_ready_2", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_addr_3",  out_addr,  32'h0000_3008);
    check("bp_instr_3", out_instr, 32'h34011234);
    tick();
    out_ready = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Reserved format: dropped, sticky err, address unchanged; restart clears.
    send(2'd3, 6'h3f, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3f, 16'hffff, 26'h3ffffff);
    check("rsvd_err",   32'(err),       32'd1);
    check("rsvd_valid", 32'(out_valid), 32'd0);
    send(2'd0, 6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 16'h0, 26'h0);
    check("rsvd_next_addr", out_addr, 32'h0000_300c);
    pulse_restart();
    check("restart_err",   32'(err),       32'd0);
    check("restart_empty", 32'(out_valid), 32'd0);

    // beq: delay slot nop when enabled, none otherwise.
    send(2'd1, 6'd4, 5'd1, 5'd2, 0, 0, 0, 16'hffff, 26'h0);
    check("beq_instr", out_instr, 32'h1022ffff);
    check("beq_addr",  out_addr,  32'h0000_3000);
`ifdef INSTR_PACK_DELAY_SLOT_EN
    check("beq_slot_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("nop_instr",  out_instr, 32'h0000_0000);
    check("nop_addr",   out_addr,  32'h0000_3004);
    check("nop_ready",  32'(in_ready), 32'd1);
`else
    check("beq_ready", 32'(in_ready), 32'd1);
    send(2'd1, 6'h0d, 5'd0, 5'd1, 0, 0, 0, 16'h1234, 26'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("beq_next_instr", out_instr, 32'h34011234);
    check("beq_next_addr",  out_addr,  32'h0000_3004);
`endif
    drain();

    // Async reset between edges with FIFO full (and a slot pending when enabled).
    pulse_restart();
    send(2'd3, 6'd0, 0, 0, 0, 0, 0, 16'h0, 26'h0);
    send(2'd1, 6'h0d, 5'd0, 5'd1, 0, 0, 0, 16'h1234, 26'h0);
    send(2'd2, 6'd2, 0, 0, 0, 0, 0, 16'h0, 26'h0000123);
    check("pre_arst_full", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_err",       32'(err),       32'd0);
    tick();
    reset = 1'b1;
    send(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
    check("post_arst_addr", out_addr, 32'h0000_3000);
    drain();

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      fmt = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       opcode = 6'd0;
        1:       opcode = 6'd2;
        2:       opcode = 6'd3;
        3:       opcode = 6'd4;
        4:       opcode = 6'd5;
        default: opcode = 6'($urandom);
      endcase
      rs          = 5'($urandom);
      rt          = 5'($urandom);
      rd          = 5'($urandom);
      shamt       = 5'($urandom);
      funct       = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      immediate   = 16'($urandom);
      instr_index = 26'($urandom);
      out_ready   = (i % 200 < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      restart     = ($urandom_range(0, 79) == 0);
      tick();
    end
    in_valid = 1'b0;
    restart  = 1'b0;
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
